fifo_wdc: RTL
=============

# fifo_wdc

Single-clock, parametrised width-down-converting FIFO. Wide words from an upstream producer are buffered in an internal register array of `DEPTH` entries and streamed out as `RATIO` narrow slices, least-significant slice first, paced by a downstream ready. It sits between a wide-datapath stage and a narrow serial or byte-oriented consumer in the same clock domain. It generalises the fixed 16-to-8 two-beat reader to any slice width, ratio and depth, and adds almost-full, fill-level and optional drop-count status.

## Interface
Parameters:
- `OUT_W`, 8, output slice width in bits (≥1)
- `RATIO`, 2, slices per input word (≥1); the derived input width is `IN_W = OUT_W*RATIO`
- `DEPTH`, 64, FIFO entries; must be a power of 2, ≥2
- `AFULL_TH`, 61, fill level at which `in_afull` asserts (1..DEPTH)

Ports:
- `clk` in 1: single clock; all logic on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `data_in` in IN_W: input word
- `data_in_vld` in 1: input word valid this cycle
- `in_afull` out 1: fill level ≥ `AFULL_TH`
- `usedw` out clog2(DEPTH)+1: current fill level, 0..DEPTH
- `data_out` out OUT_W: output slice
- `data_out_vld` out 1: `data_out` valid this cycle
- `b_rdy` in 1: downstream can accept a slice on the next cycle
- `drop_cnt` out 16: count of input words dropped because the FIFO was full

## Operation
- Storage: `mem[DEPTH]` of IN_W bits, plus `wr_ptr` and `rd_ptr` of clog2(DEPTH) bits each (natural wrap), and `count` of clog2(DEPTH)+1 bits. `usedw = count`.
- Write accept: `wr = data_in_vld && count < DEPTH`. The comparison uses `count` from before the edge. A pop in the same cycle does not free a slot for that write.
- Drop: `data_in_vld && count == DEPTH`. The word is discarded and `drop_cnt` increments (see Configuration).
- Slice counter `cnt`, width max(1, clog2(RATIO)):
  - `fire = count != 0 && b_rdy`
  - On `fire`, `cnt` increments; when `cnt == RATIO-1` it returns to 0.
  - `pop = fire && cnt == RATIO-1`
- Output register:
  - On `fire`: `data_out <= mem[rd_ptr][cnt*OUT_W +: OUT_W]`; otherwise `data_out` holds.
  - `data_out_vld <= fire` every cycle.
- Pointer and count updates:
  - `wr` increments `wr_ptr`; `pop` increments `rd_ptr`.
  - `count` changes by +1 for `wr` only, −1 for `pop` only, and is unchanged for both or neither.
- `in_afull = count >= AFULL_TH`. Combinational from the registered `count`; no added latency.
- `b_rdy` low mid-word: `cnt` holds. The word stays at the head and resumes at the same slice.
- `RATIO == 1`: `cnt` stays 0 and every `fire` is a `pop`.
- Reset mid-word: the partial word is discarded. Pointers, `count` and `cnt` are cleared.

## Timing
- Reset values: `data_out = 0`, `data_out_vld = 0`, `usedw = 0`, `in_afull = 0` (AFULL_TH ≥ 1), `drop_cnt = 0`.
- Write-to-output latency with the FIFO empty and `b_rdy` high:
  - Word written at edge N is readable in cycle N+1 (`count = 1`).
  - Slice 0 is registered at edge N+1, so `data_out_vld` is high in cycle N+2.
- Sustained throughput with `b_rdy` high: one slice per cycle and one word per RATIO cycles. No bubble between words.
- `b_rdy` in cycle N governs `data_out_vld` in cycle N+1.
- Simultaneous `wr` and `pop`: `count` is unchanged. The write lands at `wr_ptr` and the read advances `rd_ptr`, with no hazard.
- Pointer wrap from `DEPTH-1` to 0 is seamless.
- `usedw` reflects the edge just taken; no extra pipeline stage.

## Configuration
- `FIFO_WDC_DROP_CNT_EN` defined: `drop_cnt` is a 16-bit counter.
  - It increments on every drop.
  - It saturates at 16'hFFFF.
  - It clears only on reset.
- `FIFO_WDC_DROP_CNT_EN` not defined: `drop_cnt` is tied to 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Reset, OUT_W=8, RATIO=2: all outputs 0. Write 16'hA55A at edge N with `b_rdy` high. Expected: `data_out` = 8'h5A with vld in cycle N+2, then 8'hA5 in cycle N+3, vld low in cycle N+4, `usedw` back to 0.
- Burst of 64 words 0..63 with `b_rdy` low: `usedw` = 64, `in_afull` high from the 61st write. The 65th word (16'hFFFF) is dropped, and `drop_cnt` = 1 with the macro, 0 without. Raise `b_rdy`: exactly 128 slices emerge in order 00,00,01,00,...,3F,00.
- Toggle `b_rdy` every cycle during a stream: no slice is lost or duplicated, `cnt` holds across gaps, and the output equals the input split LSB-first.
- Write and pop in the same cycle at `usedw` = 10 for 20 cycles: `usedw` stays 10 and the pointers wrap past 63 correctly.
- At `usedw` = 64 with a `pop` and a `data_in_vld` in the same cycle: the write is dropped and `usedw` becomes 63.
- Assert `rst_n` low for one cycle after slice 0 of a word: outputs go to 0 immediately. After release, `usedw` = 0 and no residual slice appears.

Source files
------------

// File: rtl/fifo_wdc.sv
// fifo_wdc: single-clock FIFO that streams each wide word out as RATIO slices, LSB first.
// Define FIFO_WDC_DROP_CNT_EN to build the saturating drop counter on drop_cnt.
module fifo_wdc #(
    parameter int OUT_W    = 8,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 64,
    parameter int AFULL_TH = 61
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OUT_W*RATIO-1:0]   data_in,
    input  logic                     data_in_vld,
    output logic                     in_afull,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic [OUT_W-1:0]         data_out,
    output logic                     data_out_vld,
    input  logic                     b_rdy,
    output logic [15:0]              drop_cnt
);

    localparam int IN_W = OUT_W * RATIO;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF   = (AW+1)'(AFULL_TH);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   cnt;
    logic [IN_W-1:0] head;
    logic            wr;
    logic            fire;
    logic            pop;

    // A pop in the same cycle never frees a slot for the write.
    assign wr       = data_in_vld && (count < FULL);
    assign fire     = (count != '0) && b_rdy;
    assign pop      = fire && (cnt == LAST);
    assign head     = mem[rd_ptr];
    assign usedw    = count;
    assign in_afull = (count >= AF);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cnt          <= '0;
            data_out     <= '0;
            data_out_vld <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            data_out_vld <= fire;
            if (fire) begin
                data_out <= head[int'(cnt)*OUT_W +: OUT_W];
                cnt      <= pop ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_WDC_DROP_CNT_EN
    logic drop;

    assign drop = data_in_vld && (count == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
